obsm: RTL and testbench

- Output-side state machine of the 4-port packet router; the other end of the input-buffer request/ack handshake.
- Collects the one-hot requests that the four input-buffer controllers raise for this output and grants one of them round-robin with a one-cycle `ack`.
- Then steers the granted port's flit stream into the output FIFO until the tail flit is written.

---
 rtl/obsm.sv | 161 ++++++++++++++++
 tb/tb_obsm.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/obsm.sv
// obsm: output-side state machine of the 4-port packet router.
// Grants one requesting input port at a time, round-robin, with a one-cycle
// ack pulse.  It then steers that port's flits into the output FIFO until the
// tail flit is written.
// Optional build macro OBSM_TIMEOUT_EN adds an idle-flit watchdog in XFER.
// Handshake: a flit moves when vld[gsel] is high in XFER.  It is written when
// full is low and dropped, with err set, when full is high.  There is no
// stall; the input side never waits on this block.
module obsm #(
  parameter int DW        = 10,
  parameter int TO_CYCLES = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      req,
  output logic [3:0]      ack,
  input  logic [4*DW-1:0] pkti,
  input  logic [3:0]      vld,
  input  logic            afull,
  input  logic            full,
  output logic [DW-1:0]   pkto,
  output logic            we,
  output logic            busy,
  output logic            err,
  output logic [2:0]      dbg_state,
  output logic [1:0]      dbg_rr,
  output logic [1:0]      dbg_gsel
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'b001,
    S_GRANT = 3'b010,
    S_XFER  = 3'b100
  } state_t;

  localparam logic [1:0] T_HEAD = 2'b10;
  localparam logic [1:0] T_TAIL = 2'b01;
  localparam logic [1:0] T_RSVD = 2'b11;

  // A watchdog limit of zero would make the timeout compare meaningless.
  if (TO_CYCLES < 1) begin : g_to_cycles_check
    $error("obsm: TO_CYCLES must be at least 1");
  end

  state_t      state;
  logic [1:0]  rr;
  logic [1:0]  gsel;
  logic        first;

  logic [1:0]    sel;
  logic          any_req;
  logic [DW-1:0] flit;
  logic [1:0]    ftype;
  logic          gvld;
  logic          wr;

`ifdef OBSM_TIMEOUT_EN
  localparam int CW = $clog2(TO_CYCLES + 1);
  logic [CW-1:0] tocnt;
`endif

  // Round-robin pick: first set req bit scanning upward from rr, wrapping mod 4.
  always_comb begin
    logic [1:0] idx;
    sel     = rr;
    any_req = 1'b0;
    idx     = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      idx = rr + 2'(i);
      if (req[idx]) begin
        sel     = idx;
        any_req = 1'b1;
      end
    end
  end

  // Zero-latency flit path from the granted port to the output FIFO.
  always_comb begin
    flit  = pkti[int'(gsel)*DW +: DW];
    ftype = flit[DW-1:DW-2];
    gvld  = vld[gsel];
    wr    = (state == S_XFER) && gvld && !full;
    we    = wr;
    pkto  = wr ? flit : '0;
  end

  assign dbg_state = state;
  assign dbg_rr    = rr;
  assign dbg_gsel  = gsel;

  // Arbitration / transfer FSM with registered ack, busy and sticky err.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      rr    <= 2'd0;
      gsel  <= 2'd0;
      ack   <= 4'b0000;
      busy  <= 1'b0;
      err   <= 1'b0;
      first <= 1'b0;
`ifdef OBSM_TIMEOUT_EN
      tocnt <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req && !afull) begin
            gsel  <= sel;
            rr    <= sel + 2'd1;
            ack   <= 4'b0001 << sel;
            busy  <= 1'b1;
            state <= S_GRANT;
          end
        end
        S_GRANT: begin
          ack   <= 4'b0000;
          first <= 1'b1;
`ifdef OBSM_TIMEOUT_EN
          tocnt <= '0;
`endif
          state <= S_XFER;
        end
        S_XFER: begin
          if (gvld) begin
            if (full) begin
              // Overflow: flit is dropped, packet keeps going.
              err <= 1'b1;
            end else begin
              first <= 1'b0;
              if (ftype == T_RSVD) err <= 1'b1;
              // A second head is flagged and otherwise passed as a body flit.
              if (ftype == T_HEAD && !first) err <= 1'b1;
              if (ftype == T_TAIL) begin
                busy  <= 1'b0;
                state <= S_IDLE;
              end
            end
          end
`ifdef OBSM_TIMEOUT_EN
          // Watchdog on consecutive cycles without a valid flit.
          if (gvld) begin
            tocnt <= '0;
          end else if (tocnt == CW'(TO_CYCLES - 1)) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            tocnt <= tocnt + 1'b1;
          end
`endif
        end
        default: begin
          ack   <= 4'b0000;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_obsm.sv
// Directed testbench for obsm: reset, single packet, round-robin, afull
// backpressure, port isolation, overflow, framing errors, reset mid-transfer,
// and the idle-flit watchdog (or its absence in the default build).
module tb_obsm;
  localparam int DW = 10;

  logic            clk;
  logic            rst;
  logic [3:0]      req;
  logic [3:0]      ack;
  logic [4*DW-1:0] pkti;
  logic [3:0]      vld;
  logic            afull;
  logic            full;
  logic [DW-1:0]   pkto;
  logic            we;
  logic            busy;
  logic            err;
  logic [2:0]      dbg_state;
  logic [1:0]      dbg_rr;
  logic [1:0]      dbg_gsel;

  int tests;
  int failed;
  int wr_cnt;

  localparam logic [2:0] ST_IDLE  = 3'b001;
  localparam logic [2:0] ST_GRANT = 3'b010;
  localparam logic [2:0] ST_XFER  = 3'b100;

  obsm #(.DW(DW), .TO_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .req(req), .ack(ack), .pkti(pkti), .vld(vld),
    .afull(afull), .full(full), .pkto(pkto), .we(we), .busy(busy), .err(err),
    .dbg_state(dbg_state), .dbg_rr(dbg_rr), .dbg_gsel(dbg_gsel)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; req = '0; vld = '0; afull = 1'b0; full = 1'b0; pkti = '0;
    next();
    next();
    rst = 1'b1;
    next();
  endtask

  // Present one flit on port p, check the write strobe and data, then clock it.
  task automatic xfer_flit(input int p, input logic [DW-1:0] f, input logic exp_we);
    vld = '0;
    pkti[p*DW +: DW] = f;
    vld[p] = 1'b1;
    #1;
    chk("we", 32'(we), 32'(exp_we));
    chk("pkto", 32'(pkto), exp_we ? 32'(f) : 32'h0);
    if (we) wr_cnt++;
    next();
    vld = '0;
  endtask

  // Request with reqv, expect the grant on port g, then move into XFER.
  task automatic grant(input logic [3:0] reqv, input int g, input logic hold);
    req = reqv;
    next();
    chk("ack", 32'(ack), 32'(4'b0001 << g));
    chk("busy_grant", 32'(busy), 32'h1);
    if (!hold) req = '0;
    next();
    chk("ack_clear", 32'(ack), 32'h0);
    chk("state_xfer", 32'(dbg_state), 32'(ST_XFER));
  endtask

  initial begin
    tests = 0; failed = 0; wr_cnt = 0;
    rst = 1'b0; req = '0; vld = '0; afull = 1'b0; full = 1'b0; pkti = '0;
    next();
    next();
    // Reset state
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_we", 32'(we), 32'h0);
    chk("rst_pkto", 32'(pkto), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_rr", 32'(dbg_rr), 32'h0);
    rst = 1'b1;
    next();

    // Single packet on port 2
    grant(4'b0100, 2, 1'b0);
    chk("rr_after_p2", 32'(dbg_rr), 32'h3);
    next();
    xfer_flit(2, 10'h202, 1'b1);
    xfer_flit(2, 10'h005, 1'b1);
    xfer_flit(2, 10'h00A, 1'b1);
    xfer_flit(2, 10'h10F, 1'b1);
    chk("single_idle", 32'(dbg_state), 32'(ST_IDLE));
    chk("single_busy", 32'(busy), 32'h0);
    chk("single_err", 32'(err), 32'h0);
    chk("single_wr_cnt", 32'(wr_cnt), 32'h4);
    chk("single_rr", 32'(dbg_rr), 32'h3);

    // Round-robin with all four requesting
    do_reset();
    for (int g = 0; g < 5; g++) begin
      grant(4'b1111, g % 4, 1'b1);
      next();
      xfer_flit(g % 4, 10'h201, 1'b1);
      xfer_flit(g % 4, 10'h101, 1'b1);
    end
    req = '0;

    // Backpressure: rr is now 1, only port 0 requests
    afull = 1'b1;
    req = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      next();
      chk("afull_noack", 32'(ack), 32'h0);
      chk("afull_idle", 32'(dbg_state), 32'(ST_IDLE));
    end
    afull = 1'b0;
    grant(4'b0001, 0, 1'b0);
    next();
    xfer_flit(0, 10'h200, 1'b1);
    xfer_flit(0, 10'h100, 1'b1);

    // Isolation: port 1 granted, port 3 chatters with random data
    grant(4'b0010, 1, 1'b0);
    next();
    begin
      logic [DW-1:0] f1 [4];
      int k;
      f1[0] = 10'h2A1; f1[1] = 10'h033; f1[2] = 10'h0C4; f1[3] = 10'h155;
      k = 0;
      for (int s = 0; s < 7; s++) begin
        vld = '0;
        vld[3] = 1'($urandom_range(0, 1));
        pkti[3*DW +: DW] = DW'($urandom_range(0, 1023));
        if (s % 2 == 0) begin
          pkti[1*DW +: DW] = f1[k];
          vld[1] = 1'b1;
        end
        #1;
        chk("iso_we", 32'(we), 32'(vld[1]));
        chk("iso_pkto", 32'(pkto), vld[1] ? 32'(f1[k]) : 32'h0);
        if (vld[1]) k++;
        next();
      end
      vld = '0;
      chk("iso_idle", 32'(dbg_state), 32'(ST_IDLE));
      chk("iso_err", 32'(err), 32'h0);
    end

    // Overflow on body flit 2 of a 4-flit packet (rr=2 -> port 0)
    wr_cnt = 0;
    grant(4'b0001, 0, 1'b0);
    next();
    xfer_flit(0, 10'h211, 1'b1);
    xfer_flit(0, 10'h022, 1'b1);
    full = 1'b1;
    xfer_flit(0, 10'h033, 1'b0);
    chk("ovf_err", 32'(err), 32'h1);
    chk("ovf_still_xfer", 32'(dbg_state), 32'(ST_XFER));
    full = 1'b0;
    xfer_flit(0, 10'h144, 1'b1);
    chk("ovf_wr_cnt", 32'(wr_cnt), 32'h3);
    chk("ovf_idle", 32'(dbg_state), 32'(ST_IDLE));
    next();
    next();
    chk("ovf_err_sticky", 32'(err), 32'h1);

    // Second head mid-packet: flagged, written as body
    do_reset();
    grant(4'b1000, 3, 1'b0);
    next();
    xfer_flit(3, 10'h200, 1'b1);
    chk("head1_err", 32'(err), 32'h0);
    xfer_flit(3, 10'h2FF, 1'b1);
    chk("head2_err", 32'(err), 32'h1);
    chk("head2_xfer", 32'(dbg_state), 32'(ST_XFER));
    xfer_flit(3, 10'h100, 1'b1);
    chk("head2_idle", 32'(dbg_state), 32'(ST_IDLE));

    // Reserved flit type: flagged, still written
    do_reset();
    grant(4'b0001, 0, 1'b0);
    next();
    xfer_flit(0, 10'h3AA, 1'b1);
    chk("rsvd_err", 32'(err), 32'h1);
    xfer_flit(0, 10'h100, 1'b1);

    // Reset asserted mid-XFER drops outputs at once (rr=1 -> port 1)
    grant(4'b0010, 1, 1'b0);
    next();
    vld = 4'b0010;
    pkti[1*DW +: DW] = 10'h201;
    #1;
    chk("mid_we_before", 32'(we), 32'h1);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_we", 32'(we), 32'h0);
    chk("mid_ack", 32'(ack), 32'h0);
    chk("mid_busy", 32'(busy), 32'h0);
    chk("mid_pkto", 32'(pkto), 32'h0);
    chk("mid_state", 32'(dbg_state), 32'(ST_IDLE));
    vld = '0;
    rst = 1'b1;
    next();

`ifdef OBSM_TIMEOUT_EN
    // Watchdog: 8 idle cycles after the head abort the packet
    grant(4'b0010, 1, 1'b0);
    xfer_flit(1, 10'h201, 1'b1);
    repeat (7) next();
    chk("to_before", 32'(dbg_state), 32'(ST_XFER));
    chk("to_err_before", 32'(err), 32'h0);
    next();
    chk("to_idle", 32'(dbg_state), 32'(ST_IDLE));
    chk("to_err", 32'(err), 32'h1);
    chk("to_busy", 32'(busy), 32'h0);
    grant(4'b0010, 1, 1'b0);
`else
    // Without the watchdog XFER waits for the tail indefinitely
    grant(4'b0010, 1, 1'b0);
    xfer_flit(1, 10'h201, 1'b1);
    repeat (20) next();
    chk("nto_xfer", 32'(dbg_state), 32'(ST_XFER));
    chk("nto_err", 32'(err), 32'h0);
    xfer_flit(1, 10'h100, 1'b1);
    chk("nto_idle", 32'(dbg_state), 32'(ST_IDLE));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
